// File: rtl/dec32_pkg.sv
// Shared Decimal32 datapath definitions: significand/GRS geometry, GRS field
// slices, aligner FSM states and the sticky digit encoding.
package dec32_pkg;

    localparam int DIGITS = 7;
    localparam int MANT_W = 4 * DIGITS;
    localparam int GRS_W  = 12;

    localparam int GUARD_HI  = 11;
    localparam int GUARD_LO  = 8;
    localparam int ROUND_HI  = 7;
    localparam int ROUND_LO  = 4;
    localparam int STICKY_HI = 3;
    localparam int STICKY_LO = 0;

    localparam logic [3:0] STICKY_ONE = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/bcd_digit_shift_stage.sv
// One-digit right shift of a BCD significand with guard/round/sticky update.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Sticky is carried as a flag; the caller expands it to a digit.
module bcd_digit_shift_stage #(
    parameter int DIGITS = 7
) (
    input  logic [4*DIGITS-1:0] mant,
    input  logic [3:0]          guard,
    input  logic [3:0]          round,
    input  logic                sticky,
    output logic [4*DIGITS-1:0] mant_nxt,
    output logic [3:0]          guard_nxt,
    output logic [3:0]          round_nxt,
    output logic                sticky_nxt
);

    assign mant_nxt   = {4'h0, mant[4*DIGITS-1:4]};
    assign guard_nxt  = mant[3:0];
    assign round_nxt  = guard;
    assign sticky_nxt = sticky | (round != 4'h0);

endmodule

// File: rtl/bcd_align_shifter.sv
// Sequential BCD right-aligner producing the GRS word for rounding; optional BCD_ALIGN_EARLY_EXIT_EN.
// Latency: 1 + min(in_shift, MAX_SHIFT) cycles from accept to out_valid (shorter with early exit).
// Backpressure: holds the result and all state while out_valid && !out_ready; no same-cycle re-accept.
module bcd_align_shifter
    import dec32_pkg::*;
#(
    parameter int DIGITS    = 7,
    parameter int SHIFT_W   = 8,
    parameter int MAX_SHIFT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_mant,
    input  logic [SHIFT_W-1:0]  in_shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_mant,
    output logic [GRS_W-1:0]    out_grs,
    output logic [SHIFT_W-1:0]  out_shifted
);

    align_state_t        state_q, state_d;
    logic [4*DIGITS-1:0] mant_q, mant_d, mant_sh;
    logic [3:0]          guard_q, guard_d, guard_sh;
    logic [3:0]          round_q, round_d, round_sh;
    logic                sticky_q, sticky_d, sticky_sh;
    logic [SHIFT_W-1:0]  cnt_q, cnt_d;
    logic [SHIFT_W-1:0]  shifted_q, shifted_d;
    logic [SHIFT_W-1:0]  load_cnt;
    logic                early_exit;

    // Beyond DIGITS+2 shifts nothing changes, so the count saturates.
    assign load_cnt = (in_shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : in_shift;

`ifdef BCD_ALIGN_EARLY_EXIT_EN
    assign early_exit = (mant_q == '0) && (guard_q == 4'h0) && (round_q == 4'h0);
`else
    assign early_exit = 1'b0;
`endif

    bcd_digit_shift_stage #(.DIGITS(DIGITS)) u_stage (
        .mant       (mant_q),
        .guard      (guard_q),
        .round      (round_q),
        .sticky     (sticky_q),
        .mant_nxt   (mant_sh),
        .guard_nxt  (guard_sh),
        .round_nxt  (round_sh),
        .sticky_nxt (sticky_sh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mant_q    <= '0;
            guard_q   <= 4'h0;
            round_q   <= 4'h0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            shifted_q <= '0;
        end else begin
            state_q   <= state_d;
            mant_q    <= mant_d;
            guard_q   <= guard_d;
            round_q   <= round_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            shifted_q <= shifted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mant_d    = mant_q;
        guard_d   = guard_q;
        round_d   = round_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        shifted_d = shifted_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d    = in_mant;
                    guard_d   = 4'h0;
                    round_d   = 4'h0;
                    sticky_d  = 1'b0;
                    cnt_d     = load_cnt;
                    shifted_d = '0;
                    state_d   = (load_cnt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (early_exit) begin
                    state_d = ST_DONE;
                end else begin
                    mant_d    = mant_sh;
                    guard_d   = guard_sh;
                    round_d   = round_sh;
                    sticky_d  = sticky_sh;
                    cnt_d     = cnt_q - SHIFT_W'(1);
                    shifted_d = shifted_q + SHIFT_W'(1);
                    if (cnt_q == SHIFT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_mant    = mant_q;
    assign out_shifted = shifted_q;
    assign out_grs[GUARD_HI:GUARD_LO]   = guard_q;
    assign out_grs[ROUND_HI:ROUND_LO]   = round_q;
    assign out_grs[STICKY_HI:STICKY_LO] = sticky_q ? STICKY_ONE : 4'h0;

endmodule

// File: doc/bcd_align_shifter.md
Name: bcd_align_shifter

Overview:
- Sequential right-aligner for the 7-digit BCD significand (Decimal32 datapath). It runs ahead of the decimal adder and rounding stage.
- It shifts the smaller-exponent operand right one BCD digit per clock. Displaced digits become the 12-bit GRS field: guard digit, round digit, sticky digit.
- It is the producer of the GRS word that the rounding logic consumes. It uses a valid/ready handshake on both sides.

Parameters:
- DIGITS, 7, number of BCD digits in the significand; significand width = 4*DIGITS.
- SHIFT_W, 8, width of the shift-amount input.
- MAX_SHIFT, 10, shift-cycle cap. Beyond DIGITS+2 digits the result no longer changes; must be >= DIGITS+2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_mant  input  4*DIGITS  BCD significand, digit 0 = [3:0].
- in_shift  input  SHIFT_W  digits to shift right (exponent difference).
- out_valid  output  1  aligned result available.
- out_ready  input  1  consumer accepts result.
- out_mant  output  4*DIGITS  shifted BCD significand.
- out_grs  output  12  [11:8] guard digit, [7:4] round digit, [3:0] sticky digit (4'h1 or 4'h0).
- out_shifted  output  SHIFT_W  digit shifts actually performed.

Behaviour:
- Reset (synchronous, active-high, wins over all other activity including mid-shift):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_mant=0, out_grs=0, out_shifted=0.
  - Any in-flight operand is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_mant, clear G/R/S, load cnt=min(in_shift, MAX_SHIFT).
  - Next state is SHIFT if cnt!=0, else DONE.
- SHIFT, each cycle:
  - S <= S | (R!=0).
  - R <= G.
  - G <= mant[3:0].
  - mant <= {4'h0, mant[4*DIGITS-1:4]}.
  - cnt decrements; move to DONE when cnt reaches 0. in_ready=0.
- DONE:
  - out_valid=1. Outputs are stable and held until out_ready.
  - On out_valid&&out_ready, go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Latency from accept to out_valid:
  - 1 + min(in_shift, MAX_SHIFT) cycles.
  - in_shift=0 gives 1 cycle; out_grs=12'h000 and out_mant=in_mant.
- Sticky is a digit value: 4'h1 if any nonzero digit was pushed past the round position, else 4'h0.
- Digits are moved without BCD validity checking; non-BCD nibbles pass through unchanged.
- out_shifted = number of SHIFT cycles executed, so it is <= MAX_SHIFT.
- Shift amounts > MAX_SHIFT saturate:
  - out_mant=0 and G=R=0.
  - S = OR of all input digits.
- Backpressure: while out_valid&&!out_ready, all outputs and internal state are frozen.

Optional Feature:
- Macro: BCD_ALIGN_EARLY_EXIT_EN.
- Defined: in SHIFT, when mant==0, G==0 and R==0, the FSM jumps to DONE on that cycle without further shifts. The result is identical to the full shift; out_shifted reports the shifts actually performed, and latency shrinks.
- Undefined: always performs min(in_shift, MAX_SHIFT) shift cycles.

Decomposition:
- Shared package (dec32_pkg):
  - DIGITS, MANT_W=28, GRS_W=12.
  - Localparams for GRS field slices (GUARD_HI/LO, ROUND_HI/LO, STICKY_HI/LO).
  - FSM state enum.
  - STICKY_ONE=4'h1 constant.
- One natural sub-module: bcd_digit_shift_stage. It is combinational, performing one-digit right shift with G/R/S update, and is instantiated once inside the FSM loop.

Test Plan:
- in_mant=28'h1234567, in_shift=2 -> out_mant=28'h0012345, out_grs=12'h670, out_shifted=2, out_valid 3 cycles after accept.
- in_mant=28'h1234567, in_shift=3 -> out_mant=28'h0001234, out_grs=12'h561 (digit 7 into sticky).
- in_mant=28'h1000000, in_shift=7/8/9 -> out_mant=0 in all three cases.
  - Shift 7: out_grs=12'h100.
  - Shift 8: out_grs=12'h010.
  - Shift 9: out_grs=12'h001.
- in_shift=0 -> output equals input, grs=12'h000, 1-cycle latency. in_shift=8'd200, in_mant=28'h0000003 -> out_mant=0, out_grs=12'h001, out_shifted=10.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> outputs stable, in_ready=0. Release -> in_ready=1 next cycle, back-to-back operand accepted.
- Assert rst during SHIFT with in_shift=6 -> next cycle FSM in IDLE, out_valid=0, all outputs 0. Following operand produces correct result.
